// File: rtl/core_pkg.sv
// Core-wide types: LSU opcode encodings, skid-buffer state, EX/MEM payload.
// Imported by the EX/MEM register and its misalignment checker.
package core_pkg;

    import width_param::*;

    typedef enum logic [LSU_OP_W-1:0] {
        LSU_LD_B  = 4'b0000,
        LSU_LD_H  = 4'b0001,
        LSU_LD_W  = 4'b0010,
        LSU_ST_B  = 4'b0100,
        LSU_ST_H  = 4'b0101,
        LSU_ST_W  = 4'b0110,
        LSU_LD_BU = 4'b1000,
        LSU_LD_HU = 4'b1001,
        LSU_NONE  = 4'b1111
    } lsu_op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     inst;
        logic                  rw_en;
        logic [REG_ADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]     ex_result;
        logic [LSU_OP_W-1:0]   lsu_op;
        logic [DATA_W-1:0]     lsu_data;
        logic                  ale;
    } ex_mem_t;

endpackage

// File: rtl/width_param.sv
// Shared width constants for the execute/memory pipeline slice.
// Every package and module that sizes a datapath field takes it from here.
package width_param;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LSU_OP_W   = 4;

endpackage

// File: rtl/ale_check.sv
// Address-misalignment detector for loads and stores.
// Halfwords need bit 0 clear, words need bits 1:0 clear.
module ale_check
    import width_param::*;
    import core_pkg::*;
(
    input  logic [LSU_OP_W-1:0] lsu_op,
    input  logic [1:0]          addr_lo,
    output logic                ale
);

    // Decode the access size and test the low address bits for it
    always_comb begin
        ale = 1'b0;
        unique case (lsu_op)
            LSU_LD_H, LSU_LD_HU, LSU_ST_H: ale = addr_lo[0];
            LSU_LD_W, LSU_ST_W:            ale = |addr_lo;
            default:                       ale = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with a one-entry skid buffer.
// in_ready depends only on registered state, so no ready path crosses it.
module ex_mem_pipe
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LSU_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_inst,
    input  logic [DATA_WIDTH-1:0]     in_ex_result,
    input  logic [DATA_WIDTH-1:0]     in_lsu_data,
    input  logic                      in_rw_en,
    input  logic [REG_ADDR_WIDTH-1:0] in_rw_addr,
    input  logic [LSU_OP_WIDTH-1:0]   in_lsu_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [DATA_WIDTH-1:0]     out_inst,
    output logic [DATA_WIDTH-1:0]     out_ex_result,
    output logic [DATA_WIDTH-1:0]     out_lsu_data,
    output logic                      out_rw_en,
    output logic [REG_ADDR_WIDTH-1:0] out_rw_addr,
    output logic [LSU_OP_WIDTH-1:0]   out_lsu_op,
    output logic                      out_ale
);

    pipe_state_e state;
    ex_mem_t     main_q;
    ex_mem_t     skid_q;
    ex_mem_t     cap;
    logic        ale;
    logic        fire_in;
    logic        fire_out;

    ale_check u_ale_check (
        .lsu_op  (in_lsu_op),
        .addr_lo (in_ex_result[1:0]),
        .ale     (ale)
    );

    assign in_ready  = (state != FULL) & ~rst;
    assign out_valid = (state != EMPTY);
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready;

    // Build the captured beat; a misaligned access is neutralised here
    always_comb begin
        cap.pc        = in_pc;
        cap.inst      = in_inst;
        cap.rw_en     = in_rw_en;
        cap.rw_addr   = in_rw_addr;
        cap.ex_result = in_ex_result;
        cap.lsu_op    = in_lsu_op;
        cap.lsu_data  = in_lsu_data;
        cap.ale       = ale;
        if (ale) begin
            cap.rw_en  = 1'b0;
            cap.lsu_op = LSU_NONE;
        end
    end

    // Skid-buffer state machine: main feeds MEM, skid absorbs one stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (fire_in) begin
                        state  <= HALF;
                        main_q <= cap;
                    end
                end
                HALF: begin
                    if (fire_in && fire_out) begin
                        main_q <= cap;
                    end else if (fire_in) begin
                        state  <= FULL;
                        skid_q <= cap;
                    end else if (fire_out) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire_out) begin
                        state  <= HALF;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_pc        = main_q.pc;
    assign out_inst      = main_q.inst;
    assign out_ex_result = main_q.ex_result;
    assign out_lsu_data  = main_q.lsu_data;
    assign out_rw_addr   = main_q.rw_addr;
    assign out_rw_en     = out_valid & main_q.rw_en;
    assign out_ale       = out_valid & main_q.ale;
    assign out_lsu_op    = out_valid ? main_q.lsu_op : LSU_NONE;

endmodule
